// File: rtl/anabellek_yanitlayici.sv
// Responder end of the iomem bus: word-addressed memory with byte strobes and a fixed wait.
// Optional macro ANABELLEK_RASTGELE_BEKLEME_EN adds 0..3 LFSR-driven extra wait cycles per beat.
module anabellek_yanitlayici #(
  parameter int unsigned ADRES_BIT   = 12,
  parameter logic [31:0] TABAN_ADRES = 32'h0000_0000,
  parameter int unsigned BEKLEME     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        iomem_valid_i,
  input  logic [31:0] adres_i,
  input  logic [31:0] yaz_veri_i,
  input  logic [3:0]  wr_strb_i,
  output logic        iomem_ready_o,
  output logic [31:0] anabellekten_veri_o,
  output logic        adres_hata_o
);

  localparam logic [31:0] PENCERE_MASKE = 32'((64'd4 << ADRES_BIT) - 64'd1);
  localparam logic [31:0] HATA_DESENI   = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {BOS, BEKLE, YANIT} durum_t;

  durum_t                durum_q;
  logic [4:0]            sayac_q;
  logic [4:0]            sayacYukle_d;
  logic [31:0]           adres_q;
  logic [31:0]           yazVeri_q;
  logic [3:0]            strb_q;
  logic                  ready_q;
  logic                  hata_q;
  logic [31:0]           okuVeri_q;
  logic [31:0]           mem [2**ADRES_BIT];
  logic [ADRES_BIT-1:0]  idx;
  logic                  pencereIci;
  logic                  erisim;

  assign idx        = adres_q[ADRES_BIT+1:2];
  assign pencereIci = (adres_q & ~PENCERE_MASKE) == TABAN_ADRES;
  assign erisim     = !rst_i && (durum_q == BEKLE) && iomem_valid_i && (sayac_q == 5'd0);

`ifdef ANABELLEK_RASTGELE_BEKLEME_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR, taps 8,6,5,4; free-running so the extra wait varies beat to beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign sayacYukle_d = 5'(BEKLEME) + 5'(lfsr_q[1:0]);
`else
  assign sayacYukle_d = 5'(BEKLEME);
`endif

  // The ready cycle also samples valid, so a held-valid burst sees no bubble between beats.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q   <= BOS;
      sayac_q   <= 5'd0;
      adres_q   <= 32'd0;
      yazVeri_q <= 32'd0;
      strb_q    <= 4'd0;
      ready_q   <= 1'b0;
      hata_q    <= 1'b0;
      okuVeri_q <= 32'd0;
    end else begin
      ready_q <= 1'b0;
      hata_q  <= 1'b0;
      case (durum_q)
        BOS, YANIT: begin
          if (iomem_valid_i) begin
            adres_q   <= adres_i;
            yazVeri_q <= yaz_veri_i;
            strb_q    <= wr_strb_i;
            sayac_q   <= sayacYukle_d;
            durum_q   <= BEKLE;
          end else begin
            durum_q <= BOS;
          end
        end
        BEKLE: begin
          if (!iomem_valid_i) begin
            durum_q <= BOS;
          end else if (sayac_q != 5'd0) begin
            sayac_q <= sayac_q - 5'd1;
          end else begin
            ready_q <= 1'b1;
            durum_q <= YANIT;
            if (pencereIci) begin
              okuVeri_q <= mem[idx];
            end else begin
              okuVeri_q <= HATA_DESENI;
              hata_q    <= 1'b1;
            end
          end
        end
        default: durum_q <= BOS;
      endcase
    end
  end

  // Non-blocking write lets the FSM register the pre-write word on the same edge.
  always_ff @(posedge clk_i) begin
    if (erisim && pencereIci) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) begin
          mem[idx][8*i +: 8] <= yazVeri_q[8*i +: 8];
        end
      end
    end
  end

  assign iomem_ready_o       = ready_q;
  assign anabellekten_veri_o = okuVeri_q;
  assign adres_hata_o        = hata_q;

endmodule

// File: doc/anabellek_yanitlayici.md
Name: anabellek_yanitlayici

Overview:
- Responder (slave) end of the iomem bus driven by the main-memory controller. Accepts one 32-bit word access per valid/ready handshake.
- Contains a synthesizable word-addressed memory with byte write strobes and a programmable fixed wait.
- Used as main memory on FPGA builds and as the memory model in controller and cache testbenches.

Parameters:
- ADRES_BIT, 12, word-index width; memory depth = 2^ADRES_BIT words (default 16 KiB).
- TABAN_ADRES, 32'h0000_0000, byte base address of the window; must be aligned to 4*2^ADRES_BIT.
- BEKLEME, 2, wait cycles inserted before ready; legal range 0..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- iomem_valid_i  in  1  request valid; held high by the initiator until ready.
- adres_i  in  32  byte address; bits [1:0] ignored.
- yaz_veri_i  in  32  write data.
- wr_strb_i  in  4  byte write enables; 4'b0000 = read.
- iomem_ready_o  out  1  one-cycle completion pulse.
- anabellekten_veri_o  out  32  read data; valid in the ready cycle.
- adres_hata_o  out  1  one-cycle pulse coincident with ready when the address is outside the window.

Behaviour:
- Reset (rst_i=1 at a clock edge): state goes to BOS; iomem_ready_o=0, anabellekten_veri_o=0, adres_hata_o=0, counter=0. Memory contents are not cleared.
- Reset mid-operation aborts the access. No write is performed and no ready is issued.
- BOS state: if iomem_valid_i=1, latch adres_i, yaz_veri_i and wr_strb_i. Load sayac=BEKLEME, then go to BEKLE.
- BEKLE state: while sayac!=0, decrement. When sayac==0, perform the access on that edge and go to YANIT.
- In the same edge, iomem_ready_o is registered to 1. Read data (or the error pattern) is registered to anabellekten_veri_o.
- YANIT state: ready=1 for exactly one cycle, then return to BOS. In BOS, valid is sampled again on the next edge, so back-to-back beats are accepted with no extra bubble.
- Latency: valid first high in cycle 0 gives ready high in cycle BEKLEME+1. A 4-beat burst with BEKLEME=2 completes in 4*4=16 cycles.
- Valid drop: if iomem_valid_i=0 at any edge during BEKLE, abort to BOS with no write and no ready.
- Request fields are latched only in BOS. Changes during BEKLE are ignored.
- Write: for each i with wr_strb_i[i]=1 (latched), mem[idx][8i+7:8i] <= data[8i+7:8i]. Unselected bytes are unchanged. idx = adres[ADRES_BIT+1:2].
- anabellekten_veri_o on a write returns the pre-write word at idx (read-before-write).
- Read: anabellekten_veri_o <= mem[idx]. It holds its value until the next completed access.
- Window check: in-range iff (adres & ~(4*2^ADRES_BIT-1)) == TABAN_ADRES.
  - Out of range: ready is still issued with adres_hata_o=1, no write, and anabellekten_veri_o=32'hDEAD_BEEF.
- iomem_ready_o is never high in two consecutive cycles and never high without a preceding captured request.

Optional Feature:
- Macro: ANABELLEK_RASTGELE_BEKLEME_EN.
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle. At capture in BOS, sayac loads BEKLEME + lfsr[1:0], giving 0..3 extra wait cycles per beat. All other behaviour is unchanged.
- Not defined: the LFSR is absent and the wait is exactly BEKLEME.

Test Plan:
- Reset, then idle 5 cycles -> ready, hata and data all 0; no ready pulse appears.
- BEKLEME=2: write 0x11223344 to 0x0000_0010 with strb 4'b1111 (valid at cycle 0), then read the same address -> ready at cycle 3 for the write; read returns 0x11223344 three cycles after the read request.
- Byte strobe: preload 0xAABBCCDD at 0x20, write 0x00000055 with strb 4'b0001, then read -> 0xAABBCC55.
- 4-beat read burst from 0x100..0x10C (valid held high, address stepped after each ready) with words W0..W3 preloaded -> four ready pulses spaced BEKLEME+2 cycles apart, data W0, W1, W2, W3 in order.
- Out-of-window read at 0x8000_0000 (TABAN=0, ADRES_BIT=12) -> ready and adres_hata_o high in the same cycle, data 0xDEADBEEF, memory unchanged. Write to the same address -> no memory change.
- Abort and reset: drop valid in cycle 1 of a write -> no ready, target word unchanged. Assert rst_i during BEKLE of a write -> no ready and no write; the next request completes normally.
